// File: rtl/vec_sub_stream.sv
// Streaming element-wise saturating subtractor d = a - b with output skid buffering.
// Reports the L1 norm of the differences and a sticky saturation flag at vector end.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// RUN   | accepting pairs and emitting differences
// DONE  | one cycle; norm_valid high, norm/sat_flag final
module vec_sub_stream #(
    parameter int W  = 16,
    parameter int N  = 64,
    parameter int AW = W + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  d,
    output logic          out_last,
    output logic          busy,
    output logic          norm_valid,
    output logic [AW-1:0] norm,
    output logic          sat_flag
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [AW-1:0] acc;
    logic          sat_acc;
    logic          skid_full, skid_last, skid_sat;
    logic [W-1:0]  skid_d;
    logic          out_sat;

    logic          in_hs, out_hs, start_ok;
    logic [W:0]    diff;
    logic          new_sat, new_last;
    logic [W-1:0]  new_d;
    logic [W:0]    d_abs;

    assign start_ok = (state == IDLE) && start;
    assign in_ready = (state == RUN) && (in_cnt < N_C) && !skid_full;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // One extra bit makes overflow visible as a disagreement of the top two bits.
    assign diff     = {a[W-1], a} - {b[W-1], b};
    assign new_sat  = diff[W] ^ diff[W-1];
    assign new_d    = !new_sat ? diff[W-1:0] :
                      (diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
    assign new_last = (in_cnt == LAST_C);

    assign d_abs = d[W-1] ? (~{1'b1, d} + (W+1)'(1)) : {1'b0, d};

    assign busy       = (state != IDLE);
    assign norm_valid = (state == DONE);
    assign norm       = acc;
    assign sat_flag   = sat_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (out_hs && out_cnt == LAST_C) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            acc     <= '0;
            sat_acc <= 1'b0;
        end else if (start_ok) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            acc     <= '0;
            sat_acc <= 1'b0;
        end else begin
            if (in_hs) in_cnt <= in_cnt + CW'(1);
            if (out_hs) begin
                out_cnt <= out_cnt + CW'(1);
                acc     <= acc + AW'(d_abs);
                sat_acc <= sat_acc | out_sat;
            end
        end
    end

    // Output register plus one-entry skid; the skid only fills while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            skid_full <= 1'b0;
            skid_d    <= '0;
            skid_last <= 1'b0;
            skid_sat  <= 1'b0;
        end else if (!out_valid || out_hs) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                d         <= skid_d;
                out_last  <= skid_last;
                out_sat   <= skid_sat;
                skid_full <= 1'b0;
            end else if (in_hs) begin
                out_valid <= 1'b1;
                d         <= new_d;
                out_last  <= new_last;
                out_sat   <= new_sat;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_hs) begin
            skid_full <= 1'b1;
            skid_d    <= new_d;
            skid_last <= new_last;
            skid_sat  <= new_sat;
        end
    end

endmodule

// File: tb/tb_vec_sub_stream.sv
// Scoreboard bench for vec_sub_stream: driver pushes reference results, monitor pops and compares.
module tb_vec_sub_stream;
    localparam int W  = 16;
    localparam int N  = 64;
    localparam int AW = W + $clog2(N);

    logic          clk, rst_n, start, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, d;
    logic          out_last, busy, norm_valid, sat_flag;
    logic [AW-1:0] norm;

    vec_sub_stream #(.W(W), .N(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .d(d),
        .out_last(out_last), .busy(busy), .norm_valid(norm_valid), .norm(norm),
        .sat_flag(sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] dv;
        logic         last;
    } item_t;

    item_t exp_q[$];
    int    norm_q[$];
    bit    sat_q[$];
    int    errors = 0, checks = 0;
    int    cyc = 0, last_hs_cyc = -10;
    int    nv_seen = 0, nv_exp = 0;
    bit    rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer difference clamped to the signed W-bit range.
    task automatic ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output logic [W-1:0] dv, output bit s, output int mag);
        int r, mx, mn;
        mx = (1 << (W - 1)) - 1;
        mn = -(1 << (W - 1));
        r  = int'($signed(av)) - int'($signed(bv));
        s  = (r > mx) || (r < mn);
        if (r > mx) r = mx;
        if (r < mn) r = mn;
        dv  = W'(r);
        mag = (r < 0) ? -r : r;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_d"}, d, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_norm_valid"}, norm_valid, 0);
        chk({tag, "_norm"}, norm, 0);
        chk({tag, "_sat_flag"}, sat_flag, 0);
    endtask

    // kind 0: a=i, b=2i; kind 1: saturation corners then random; kind 2: random
    task automatic send_vec(input int kind, input int vprob, input bit st_run,
                            input bit st_done, input int abort_after);
        int i = 0, iters = 0, nexp = 0, mag, w;
        bit sexp = 1'b0, s;
        logic [W-1:0] av, bv, dv;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        while (i < N && iters < 4000) begin
            av = W'($urandom);
            bv = W'($urandom);
            if (kind == 0) begin
                av = W'(i);
                bv = W'(2 * i);
            end else if (kind == 1 && i == 0) begin
                av = 16'h7fff;
                bv = 16'hffff;
            end else if (kind == 1 && i == 1) begin
                av = 16'h8000;
                bv = 16'h0001;
            end
            in_valid = ($urandom_range(99) < vprob);
            a        = av;
            b        = bv;
            start    = st_run && (iters == 7);
            @(negedge clk);
            if (in_valid && in_ready) begin
                ref_sub(av, bv, dv, s, mag);
                exp_q.push_back('{dv: dv, last: (i == N - 1)});
                nexp += mag;
                sexp |= s;
                i++;
            end
            iters++;
            @(posedge clk); #1;
            start = 1'b0;
            if (abort_after > 0 && i == abort_after) begin
                #1 rst_n = 1'b0;
                #1 check_reset_vals("abort");
                exp_q.delete();
                in_valid = 1'b0;
                @(posedge clk);
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        chk("vector_accept_count", i, N);
        if (kind == 0 && vprob == 100) chk("full_rate_iterations", iters, N);
        norm_q.push_back(nexp);
        sat_q.push_back(sexp);
        nv_exp++;
        w = 0;
        while (w < 2000) begin
            @(negedge clk);
            if (norm_valid) break;
            w++;
        end
        if (w >= 2000) chk("norm_valid_timeout", 0, 1);
        if (st_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: pop and compare on every output handshake and every norm pulse.
    initial begin
        item_t it;
        bit stalled_prev = 1'b0, busy_chk = 1'b0;
        logic [W-1:0] prev_d = '0;
        logic prev_last = 1'b0;
        int en, es;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled_prev = 1'b0;
                busy_chk     = 1'b0;
            end else begin
                if (out_valid && stalled_prev) begin
                    chk("d_hold_under_backpressure", d, prev_d);
                    chk("last_hold_under_backpressure", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        it = exp_q.pop_front();
                        chk("d_value", d, it.dv);
                        chk("out_last", out_last, it.last);
                    end
                    if (out_last) last_hs_cyc = cyc;
                end
                if (busy_chk) begin
                    chk("busy_after_done", busy, 0);
                    busy_chk = 1'b0;
                end
                if (norm_valid) begin
                    nv_seen++;
                    chk("norm_valid_timing", cyc, last_hs_cyc + 1);
                    if (norm_q.size() == 0) begin
                        chk("unexpected_norm_valid", 1, 0);
                    end else begin
                        en = norm_q.pop_front();
                        es = int'(sat_q.pop_front());
                        chk("norm", norm, en);
                        chk("sat_flag", sat_flag, es);
                    end
                    busy_chk = 1'b1;
                end
                stalled_prev = out_valid && !out_ready;
                prev_d       = d;
                prev_last    = out_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        #23;
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("in_ready_idle", in_ready, 0);
            chk("out_valid_idle", out_valid, 0);
        end
        in_valid = 1'b0;

        rdy_rand = 1'b0;
        send_vec(0, 100, 1'b0, 1'b0, 0);
        send_vec(1, 100, 1'b0, 1'b0, 0);

        rdy_rand = 1'b1;
        send_vec(2, 70, 1'b1, 1'b0, 0);
        send_vec(2, 70, 1'b0, 1'b1, 0);
        send_vec(2, 70, 1'b1, 1'b1, 0);

        rdy_rand = 1'b0;
        send_vec(2, 100, 1'b0, 1'b0, 20);
        send_vec(2, 100, 1'b0, 1'b0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("norm_valid_count", nv_seen, nv_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_sub_stream.md
# vec_sub_stream

Streaming element-wise signed subtractor for the OMP residual update path (r ← r − a). It is the inverse-direction counterpart of the 16-bit adder wrapper. Each vector of N two's-complement operand pairs arrives over a valid/ready handshake and leaves as saturated differences d = a − b, with a last-element flag. At vector end the block reports the L1 norm of the differences and a sticky saturation flag.

## Interface
- W, 16, element width (signed two's complement)
- N, 64, elements per vector (power of two, ≥ 2)
- AW, W+$clog2(N), norm accumulator width (unsigned)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse; begins a vector (ignored unless IDLE)
- in_valid  in  1  a/b pair valid
- in_ready  out  1  block accepts a/b this cycle
- a  in  W  minuend
- b  in  W  subtrahend
- out_valid  out  1  d valid
- out_ready  in  1  downstream accepts d
- d  out  W  saturated a − b
- out_last  out  1  d is element N−1 of the vector
- busy  out  1  state ≠ IDLE
- norm_valid  out  1  one-cycle pulse, norm/sat_flag valid
- norm  out  AW  Σ|d| over the vector
- sat_flag  out  1  some element in the vector saturated

## Operation
- States: IDLE → RUN on start. RUN → DONE when the output handshake of element N−1 occurs. DONE → IDLE unconditionally after one cycle.
- On start: clear in_cnt, out_cnt, acc, sat_acc.
- Input handshake: in_valid && in_ready. in_ready = (state==RUN) && (in_cnt < N) && !skid_full. in_ready is low in IDLE and DONE. in_valid is ignored when in_ready is low.
- Difference: compute a − b at W+1 bits. If the result > 2^(W−1)−1, d = 0x7FFF and the element is saturated. If the result < −2^(W−1), d = 0x8000 and the element is saturated. Otherwise d is the low W bits.
- Buffering: an output register plus a one-entry skid register, giving full throughput with out_ready=1. When the output register is empty or handshaking, the new element loads it. Otherwise the element goes to the skid. The skid drains into the output register on the next output handshake. Element order is preserved.
- out_last is carried with each element and is set when that element's in_cnt == N−1.
- Output handshake: out_valid && out_ready. Each handshake does three things:
  - acc += |d|, where |0x8000| = 32768 and AW bits never overflow.
  - sat_acc |= the element's sat bit.
  - out_cnt increments.
- DONE cycle: norm_valid = 1, norm = acc, sat_flag = sat_acc. norm and sat_flag hold until the next start and are valid only while norm_valid is high.
- start while RUN or DONE: ignored.
- A start pulse in the same cycle as the DONE → IDLE transition is ignored. start is only sampled in IDLE.
- rst_n low at any time, including mid-vector: all state is discarded asynchronously and in-flight elements are dropped.

## Timing
- Reset values: in_ready 0, out_valid 0, d 0, out_last 0, busy 0, norm_valid 0, norm 0, sat_flag 0. Internal state IDLE, all counters and the skid empty.
- start in cycle t: busy and in_ready are 1 from t+1.
- Latency: an element accepted in cycle t is presented with out_valid at t+1, provided the output path is free.
- Throughput: 1 element/cycle with out_ready held at 1. A vector takes N+1 cycles from the first accept to the last d, and norm_valid follows one cycle after the last output handshake.
- Backpressure: while out_ready=0 and out_valid=1, d and out_last hold stable. The block absorbs at most one more element into the skid, then in_ready drops (registered, one cycle later).
- busy stays high through DONE and falls in the cycle after norm_valid.

## Test plan
- Reset, then N=64 pairs with a=i, b=2i and out_ready=1 -> d = −i for each i, out_last only on i=63, norm_valid one cycle after the last handshake, norm = 2016, sat_flag=0.
- a=0x7FFF, b=0xFFFF (−1) on element 0 and a=0x8000, b=0x0001 on element 1 -> d = 0x7FFF then 0x8000, sat_flag=1, both elements counted as 32767 and 32768 in norm.
- Random out_ready (50%) with random in_valid over 3 back-to-back vectors -> output sequence matches the reference model exactly, no drops or duplicates, and d is stable whenever out_valid && !out_ready.
- start pulses during RUN and in the DONE cycle -> ignored: counts unaffected and exactly one norm_valid per vector.
- rst_n asserted after 20 accepted elements -> all outputs return to their reset values immediately. A following start plus a full vector yields the correct norm with no residue from the aborted vector.
- in_valid held high in IDLE, before start -> in_ready=0 and no elements are accepted or output.
